// File: rtl/non_circular_fifo.sv
// Linear burst buffer: slots fill 0..RAM_DEPTH-1 once, pointers rewind only on full drain.
// Optional sticky overflow/underflow outputs are enabled by defining NCF_ERROR_FLAGS_EN.
module non_circular_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_cs,
  input  logic                  wr_en,
  input  logic                  rd_cs,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   data_counter_out,
  output logic [ADDR_WIDTH-1:0] wr_pointer_out,
  output logic [ADDR_WIDTH-1:0] rd_pointer_out
`ifdef NCF_ERROR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  wr_end_q, wr_end_d;
  logic                  rd_end_q, rd_end_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic wr_req, rd_req;
  logic wr_acc, rd_acc;
  logic is_empty;
  logic drain;

  assign wr_req   = wr_cs & wr_en;
  assign rd_req   = rd_cs & rd_en;
  assign is_empty = (cnt_q == '0);
  assign wr_acc   = wr_req & ~wr_end_q;
  assign rd_acc   = rd_req & ~is_empty;
  // Last unread word leaves with no refill arriving: rewind the whole buffer.
  assign drain    = rd_acc & ~wr_acc & (cnt_q == CNT_ONE);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_end_d = wr_end_q;
    rd_end_d = rd_end_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;

    if (wr_acc) begin
      if (wr_ptr_q == LAST_SLOT) begin
        wr_end_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
    end

    if (rd_acc) begin
      dout_d = mem_q[rd_ptr_q];
      if (rd_ptr_q == LAST_SLOT) begin
        rd_end_d = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    if (drain) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      wr_end_d = 1'b0;
      rd_end_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_end_q <= 1'b0;
      rd_end_q <= 1'b0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_end_q <= wr_end_d;
      rd_end_q <= rd_end_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is never reset; only the control state decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out         = dout_q;
  assign full             = wr_end_q;
  assign empty            = is_empty;
  assign data_counter_out = cnt_q;
  assign wr_pointer_out   = wr_ptr_q;
  assign rd_pointer_out   = rd_ptr_q;

`ifdef NCF_ERROR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (wr_req & wr_end_q);
    udf_d = udf_q | (rd_req & is_empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_non_circular_fifo.sv
// Bench for non_circular_fifo: queue-based reference model checked every cycle plus directed literals.
// Honours NCF_ERROR_FLAGS_EN when the design is built with it.
module tb_non_circular_fifo;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_cs = 1'b0, wr_en = 1'b0, rd_cs = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty;
  logic [AW:0]   data_counter_out;
  logic [AW-1:0] wr_pointer_out, rd_pointer_out;
`ifdef NCF_ERROR_FLAGS_EN
  logic          overflow, underflow;
`endif

  non_circular_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_cs(wr_cs), .wr_en(wr_en), .rd_cs(rd_cs), .rd_en(rd_en),
    .data_in(data_in), .data_out(data_out),
    .full(full), .empty(empty), .data_counter_out(data_counter_out),
    .wr_pointer_out(wr_pointer_out), .rd_pointer_out(rd_pointer_out)
`ifdef NCF_ERROR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: unread words in a queue, slots consumed since last rewind, reads since rewind.
  logic [DW-1:0] mq[$];
  int            m_used = 0;
  int            m_rdn  = 0;
  logic [DW-1:0] m_dout = '0;
  bit            m_ovf = 1'b0, m_udf = 1'b0;

  always @(posedge clk or posedge reset) begin : model
    bit wreq, rreq, wok, rok;
    if (reset) begin
      mq.delete();
      m_used = 0;
      m_rdn  = 0;
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      wreq = wr_cs & wr_en;
      rreq = rd_cs & rd_en;
      wok  = wreq && (m_used < DEPTH);
      rok  = rreq && (mq.size() > 0);
      if (wreq && m_used == DEPTH) m_ovf = 1'b1;
      if (rreq && mq.size() == 0)  m_udf = 1'b1;
      if (rok) begin
        m_dout = mq.pop_front();
        m_rdn++;
        if (!wok && mq.size() == 0) begin
          m_used = 0;
          m_rdn  = 0;
        end
      end
      if (wok) begin
        mq.push_back(data_in);
        m_used++;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_data_out", data_out, m_dout);
      chk("m_count", data_counter_out, mq.size());
      chk("m_full", full, m_used == DEPTH);
      chk("m_empty", empty, mq.size() == 0);
      chk("m_wr_ptr", wr_pointer_out, (m_used == DEPTH) ? DEPTH - 1 : m_used);
      chk("m_rd_ptr", rd_pointer_out, (m_rdn > DEPTH - 1) ? DEPTH - 1 : m_rdn);
`ifdef NCF_ERROR_FLAGS_EN
      chk("m_overflow", overflow, m_ovf);
      chk("m_underflow", underflow, m_udf);
`endif
    end
  end

  task automatic drive(input logic wcs, input logic wen, input logic [DW-1:0] d,
                       input logic rcs, input logic ren);
    wr_cs = wcs; wr_en = wen; data_in = d; rd_cs = rcs; rd_en = ren;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d);   drive(1, 1, d, 0, 0); endtask
  task automatic rd();                          drive(0, 0, 8'h00, 1, 1); endtask
  task automatic idle();                        drive(0, 0, 8'h00, 0, 0); endtask
  task automatic wrd(input logic [DW-1:0] d);  drive(1, 1, d, 1, 1); endtask

  task automatic chk_state(input string nm, input int cnt, input int wp, input int rp,
                           input bit f, input bit e);
    chk({nm, "_cnt"}, data_counter_out, cnt);
    chk({nm, "_wp"}, wr_pointer_out, wp);
    chk({nm, "_rp"}, rd_pointer_out, rp);
    chk({nm, "_full"}, full, f);
    chk({nm, "_empty"}, empty, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #1 check_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_dout", data_out, 8'h00);
    chk_state("rst", 0, 0, 0, 0, 1);
`ifdef NCF_ERROR_FLAGS_EN
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
`endif
    reset = 1'b0;
    idle();

    wr(8'hAA); wr(8'hBB); wr(8'hCC); wr(8'hDD);
    chk_state("fill", 4, 3, 0, 1, 0);
    wr(8'hEE);
    chk_state("ovf_drop", 4, 3, 0, 1, 0);
`ifdef NCF_ERROR_FLAGS_EN
    chk("ovf_set", overflow, 1);
`endif
    idle();
    rd(); chk("rd_aa", data_out, 8'hAA); idle();
    rd(); chk("rd_bb", data_out, 8'hBB); idle();
    rd(); chk("rd_cc", data_out, 8'hCC);
    chk_state("three_rd", 1, 3, 3, 1, 0);
    wr(8'h77); wr(8'h66); wr(8'h55); wr(8'h55);
    chk_state("no_reuse", 1, 3, 3, 1, 0);
    rd();
    chk("rd_dd", data_out, 8'hDD);
    chk_state("rewind", 0, 0, 0, 0, 1);
    rd(); rd(); rd();
    chk("hold_dd", data_out, 8'hDD);
    chk_state("udf_drop", 0, 0, 0, 0, 1);
`ifdef NCF_ERROR_FLAGS_EN
    chk("udf_set", underflow, 1);
`endif

    wr(8'h11);
    chk_state("w11", 1, 1, 0, 0, 0);
    rd();
    chk("rd_11", data_out, 8'h11);

    wr(8'h01); wr(8'h02);
    wrd(8'h03);
    chk("simul_dout", data_out, 8'h01);
    chk_state("simul", 2, 3, 1, 0, 0);
    wr(8'h04);
    chk_state("refull", 3, 3, 1, 1, 0);
    wrd(8'h05);
    chk("full_wr_rd_dout", data_out, 8'h02);
    chk_state("full_wr_rd", 2, 3, 2, 1, 0);
    rd(); rd();
    chk("drain_dout", data_out, 8'h04);
    chk_state("drain", 0, 0, 0, 0, 1);
    wrd(8'h09);
    chk("empty_wr_rd_dout", data_out, 8'h04);
    chk_state("empty_wr_rd", 1, 1, 0, 0, 0);
    rd();
    chk("rd_09", data_out, 8'h09);
    drive(1, 0, 8'hAB, 1, 0);
    drive(0, 1, 8'hAC, 0, 1);
    chk_state("cs_en_gate", 0, 0, 0, 0, 1);

    for (int i = 0; i < 48; i++) begin
      drive(1'b1, (i % 3) != 2, DW'(i * 7 + 3), 1'b1, (i % 4 == 1) || (i % 4 == 2));
    end
    idle();

    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    wr(8'hA1); wr(8'hA2);
    #3 reset = 1'b1;
    #1;
    chk("midrst_dout", data_out, 8'h00);
    chk_state("midrst", 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(); idle();

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/non_circular_fifo.md
Name: non_circular_fifo

Overview:
- Single-clock, linear (non-wrapping) FIFO buffer of RAM_DEPTH entries.
- Write slots are consumed in order 0..RAM_DEPTH-1 and are never reused until the buffer fully drains; the pointers then rewind to 0.
- Used as a simple burst buffer: fill, drain, refill.
- Exposes pointers and occupancy for debug and visibility.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- ADDR_WIDTH, 2, pointer width.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of entries. Must equal 2**ADDR_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- wr_cs  in  1  write chip select.
- wr_en  in  1  write enable. A write is requested when wr_cs & wr_en.
- rd_cs  in  1  read chip select.
- rd_en  in  1  read enable. A read is requested when rd_cs & rd_en.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  registered read data.
- full  out  1  no write slot left (write region exhausted).
- empty  out  1  no unread entries.
- data_counter_out  out  ADDR_WIDTH+1  occupancy (unread entries), 0..RAM_DEPTH.
- wr_pointer_out  out  ADDR_WIDTH  next write slot.
- rd_pointer_out  out  ADDR_WIDTH  next read slot.

Behaviour:
- Reset (asynchronous, immediate) values:
  - data_out=0, full=0, empty=1, data_counter_out=0, wr_pointer_out=0, rd_pointer_out=0.
  - Internal wr_end and rd_end flags = 0.
  - Memory contents are not reset.
- Write accepted = wr_cs & wr_en & !full.
  - On the clk edge: mem[wr_pointer] <= data_in.
  - If wr_pointer == RAM_DEPTH-1: wr_end <= 1 and the pointer holds.
  - Otherwise wr_pointer increments.
- full = wr_end, registered state. It stays 1 after reads until the buffer drains; freed slots are not reused.
- Read accepted = rd_cs & rd_en & !empty.
  - On the clk edge: data_out <= mem[rd_pointer] (1-cycle latency, visible after the edge).
  - rd_pointer increments; it holds at RAM_DEPTH-1.
- data_out holds its value when no read is accepted, including rejected reads on an empty buffer.
- Occupancy update per edge: +1 for an accepted write, -1 for an accepted read, unchanged if both.
- empty = (data_counter_out == 0).
- Drain rewind: if an accepted read takes occupancy from 1 to 0 with no accepted write on that edge, then wr_pointer, rd_pointer and wr_end all return to 0 on that edge. full deasserts the following cycle.
- Simultaneous write and read:
  - Both are accepted if legal; the write uses the pre-edge wr_pointer, the read uses the pre-edge rd_pointer.
  - Empty + write + read: only the write is accepted.
  - Full + write + read: only the read is accepted.
- Rejected requests (write when full, read when empty) change no state.
- Asserting reset mid-operation aborts immediately to the reset values; stored data is discarded logically.

Optional Feature:
- Macro NCF_ERROR_FLAGS_EN.
- Defined: adds outputs overflow (1) and underflow (1), both sticky and reset to 0.
  - overflow sets on the edge of a write request while full.
  - underflow sets on the edge of a read request while empty.
  - Both are cleared only by reset.
- Undefined: these ports and their logic are absent. Rejected requests are silently dropped.

Test Plan:
- Reset, then write AA,BB,CC,DD on 4 consecutive edges -> data_counter_out=4, full=1, empty=0, wr_pointer_out=3.
- Continue the write with EE -> EE is dropped, counter stays 4 (overflow=1 if NCF_ERROR_FLAGS_EN).
- Three single-cycle reads, separated by idle cycles -> data_out=AA, then BB, then CC. Counter=1, rd_pointer_out=3, full still 1.
- While in the state above, write 77,66,55 (55 held for 2 cycles) -> all dropped, counter=1.
- Next read -> data_out=DD, empty=1, counter=0, full=0, both pointers 0.
- Three further reads -> data_out holds DD, no state change (underflow=1 if enabled).
- After rewind, write 11 and read -> 11 stored at slot 0 and read back.
- Simultaneous write+read at occupancy 2 -> counter stays 2, both pointers advance.
- Assert reset mid-fill -> all outputs return to reset values immediately.
